kart_physics: RTL

//  Produces the player kart pose (x, y, direction) that the rotated track renderer consumes.

---
 rtl/kart_physics.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kart_physics.sv
// Player kart physics: one steer/lookup/integrate step per video frame.
// State | meaning: IDLE wait for frame | STEER turn and speed | WAIT address + ROM latency | MOVE cap and integrate
module kart_physics #(
    parameter int START_X      = 1024,
    parameter int START_Y      = 1024,
    parameter int START_DIR    = 0,
    parameter int TURN_RATE    = 3,
    parameter int ACCEL        = 2,
    parameter int BRAKE        = 4,
    parameter int DRAG         = 1,
    parameter int MAX_SPEED    = 64,
    parameter int OFF_SPEED    = 16,
    parameter int OFFROAD_TILE = 0
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               frame_in,
    input  logic               accel_in,
    input  logic               brake_in,
    input  logic               left_in,
    input  logic               right_in,
    output logic [8:0]         trig_addr_out,
    input  logic signed [10:0] cos_in,
    input  logic signed [10:0] sin_in,
    output logic [7:0]         track_addr_out,
    input  logic [3:0]         tile_in,
    output logic [8:0]         direction_out,
    output logic [10:0]        player_x_out,
    output logic [10:0]        player_y_out,
    output logic [7:0]         speed_out,
    output logic               busy_out,
    output logic               step_done_out
);
    typedef enum logic [1:0] {IDLE, STEER, WAIT, MOVE} state_t;

    localparam logic [8:0]  TURN9    = 9'(TURN_RATE);
    localparam logic [7:0]  ACCEL8   = 8'(ACCEL);
    localparam logic [7:0]  BRAKE8   = 8'(BRAKE);
    localparam logic [7:0]  DRAG8    = 8'(DRAG);
    localparam logic [7:0]  MAX8     = 8'(MAX_SPEED);
    localparam logic [7:0]  OFF8     = 8'(OFF_SPEED);
    localparam logic [3:0]  OFF_TILE = 4'(OFFROAD_TILE);
    localparam logic signed [21:0] POS_MAX = 22'sd1048575;

    state_t      state, state_nxt;
    logic [1:0]  wait_cnt;
    logic [8:0]  dir;
    logic [19:0] pos_x, pos_y;
    logic [7:0]  speed;
    logic        step_done;

    logic [9:0]  dir_sum;
    logic [8:0]  dir_turn;
    logic [8:0]  spd_acc;
    logic [7:0]  speed_steer;
    logic [7:0]  speed_cap;
    logic [7:0]  cap;
    logic signed [19:0] prod_s, prod_c, dx, dy;
    logic signed [21:0] x_sum, y_sum;
    logic [19:0] x_new, y_new;

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_in) state_nxt = STEER;
            STEER:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == 2'd0) state_nxt = MOVE;
            MOVE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dir_sum     = {1'b0, dir} + {1'b0, TURN9};
        dir_turn    = dir;
        if (right_in && !left_in)
            dir_turn = (dir_sum >= 10'd360) ? 9'(dir_sum - 10'd360) : dir_sum[8:0];
        else if (left_in && !right_in)
            dir_turn = (dir < TURN9) ? 9'(dir + 9'd360 - TURN9) : 9'(dir - TURN9);

        // Brake wins over accel; all paths saturate instead of wrapping.
        spd_acc     = {1'b0, speed} + {1'b0, ACCEL8};
        if (brake_in)
            speed_steer = (speed < BRAKE8) ? 8'd0 : 8'(speed - BRAKE8);
        else if (accel_in)
            speed_steer = spd_acc[8] ? 8'hFF : spd_acc[7:0];
        else
            speed_steer = (speed < DRAG8) ? 8'd0 : 8'(speed - DRAG8);

        cap       = (tile_in == OFF_TILE) ? OFF8 : MAX8;
        speed_cap = (speed > cap) ? cap : speed;

        prod_s = $signed({1'b0, speed_cap}) * sin_in;
        prod_c = $signed({1'b0, speed_cap}) * cos_in;
        dx     = -(prod_s >>> 4);
        dy     = prod_c >>> 4;
        x_sum  = $signed({2'b00, pos_x}) + {{2{dx[19]}}, dx};
        y_sum  = $signed({2'b00, pos_y}) + {{2{dy[19]}}, dy};

        // Clamp at the world edges rather than wrapping around.
        if (x_sum < 0)            x_new = 20'd0;
        else if (x_sum > POS_MAX) x_new = 20'hFFFFF;
        else                      x_new = x_sum[19:0];
        if (y_sum < 0)            y_new = 20'd0;
        else if (y_sum > POS_MAX) y_new = 20'hFFFFF;
        else                      y_new = y_sum[19:0];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wait_cnt  <= 2'd0;
            dir       <= 9'(START_DIR);
            pos_x     <= {11'(START_X), 9'd0};
            pos_y     <= {11'(START_Y), 9'd0};
            speed     <= 8'd0;
            step_done <= 1'b0;
        end else begin
            step_done <= (state == MOVE);
            if (state == STEER) begin
                wait_cnt <= 2'd2;
                dir      <= dir_turn;
                speed    <= speed_steer;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == MOVE) begin
                speed <= speed_cap;
                pos_x <= x_new;
                pos_y <= y_new;
            end
        end
    end

    assign trig_addr_out  = dir;
    assign track_addr_out = {pos_y[19:16], pos_x[19:16]};
    assign direction_out  = dir;
    assign player_x_out   = pos_x[19:9];
    assign player_y_out   = pos_y[19:9];
    assign speed_out      = speed;
    assign busy_out       = (state != IDLE);
    assign step_done_out  = step_done;
endmodule
